vga_fifo_reader: RTL and testbench

VGA_FIFO_READER -- requirements
Module: vga_fifo_reader

---
 rtl/vga_fifo_reader.sv | 93 +++++++++
 tb/tb_vga_fifo_reader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/vga_fifo_reader.sv
// VGA raster timing that pops one FIFO word per visible pixel; de/hsync/vsync/colour appear 1 cycle after the counters.
// No backpressure: the raster never stalls, an empty FIFO yields black. `VGA_UNDERRUN_FLAG_EN adds a sticky underrun output.
module vga_fifo_reader #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       E,
   input  logic [2:0] dataIn_RGB,
   output logic       RE,
   output logic [2:0] dataOut_RGB,
   output logic       hsync,
   output logic       vsync,
   output logic       de
`ifdef VGA_UNDERRUN_FLAG_EN
   ,
   output logic       underrun
`endif
);

   localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(HT);
   localparam int VW = $clog2(VT);

   logic [HW-1:0] hcnt;
   logic [VW-1:0] vcnt;
   logic          active;
   logic          h_last;
   logic          v_last;
   logic          hs_zone;
   logic          vs_zone;
   logic          pop;

   // Comparisons done in 32-bit int so sync bounds equal to HT/VT never truncate.
   always_comb begin
      h_last  = (int'(hcnt) == HT - 1);
      v_last  = (int'(vcnt) == VT - 1);
      active  = (int'(hcnt) < H_ACTIVE) && (int'(vcnt) < V_ACTIVE);
      hs_zone = (int'(hcnt) >= H_ACTIVE + H_FP) && (int'(hcnt) < H_ACTIVE + H_FP + H_SYNC);
      vs_zone = (int'(vcnt) >= V_ACTIVE + V_FP) && (int'(vcnt) < V_ACTIVE + V_FP + V_SYNC);
   end

   assign RE = active & ~E & ~reset;

   always_ff @(posedge clock) begin
      if (reset) begin
         hcnt <= '0;
         vcnt <= '0;
      end else begin
         if (h_last) begin
            hcnt <= '0;
            vcnt <= v_last ? '0 : vcnt + VW'(1);
         end else begin
            hcnt <= hcnt + HW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pop   <= 1'b0;
         de    <= 1'b0;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else begin
         pop   <= RE;
         de    <= active;
         hsync <= ~hs_zone;
         vsync <= ~vs_zone;
      end
   end

   // FIFO data arrives the cycle after the pop, so gating it with the registered pop aligns it with de.
   assign dataOut_RGB = pop ? dataIn_RGB : 3'b000;

`ifdef VGA_UNDERRUN_FLAG_EN
   always_ff @(posedge clock) begin
      if (reset)
         underrun <= 1'b0;
      else if (active && E)
         underrun <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_vga_fifo_reader.sv
// Bench for vga_fifo_reader with a tiny raster (HT=8, VT=6); model derives raster position from cycle count.
module tb_vga_fifo_reader;

   logic       clock;
   logic       reset;
   logic       E;
   logic [2:0] dataIn_RGB;
   logic       RE;
   logic [2:0] dataOut_RGB;
   logic       hsync;
   logic       vsync;
   logic       de;
`ifdef VGA_UNDERRUN_FLAG_EN
   logic       underrun;
`endif

   vga_fifo_reader #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) dut (
      .clock(clock),
      .reset(reset),
      .E(E),
      .dataIn_RGB(dataIn_RGB),
      .RE(RE),
      .dataOut_RGB(dataOut_RGB),
      .hsync(hsync),
      .vsync(vsync),
      .de(de)
`ifdef VGA_UNDERRUN_FLAG_EN
      ,
      .underrun(underrun)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Model state: t is the raster cycle index since reset release.
   int   t      = 0;
   bit   known  = 0;
   bit   pend   = 0;
   int   w      = 1;
   int   cur_word = 0;
   bit   e_de   = 0;
   bit   e_hs   = 1;
   bit   e_vs   = 1;
   int   e_rgb  = 0;
   bit   e_ur   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0d got %0d expected %0d", nm, t, act, exp);
      end
   endtask

   task automatic cyc(input bit e, input bit rst);
      int  h;
      int  v;
      bit  act;
      bit  exp_re;
      @(negedge clock);
      E     = e;
      reset = rst;
      dataIn_RGB = pend ? 3'(cur_word) : 3'($urandom_range(1, 7));
      #1;
      h      = t % 8;
      v      = (t / 8) % 6;
      act    = (h < 4) && (v < 3);
      exp_re = !rst && act && !e;
      chk("RE", int'(RE), int'(exp_re));
      if (known) begin
         chk("de", int'(de), int'(e_de));
         chk("hsync", int'(hsync), int'(e_hs));
         chk("vsync", int'(vsync), int'(e_vs));
         chk("rgb", int'(dataOut_RGB), e_rgb);
`ifdef VGA_UNDERRUN_FLAG_EN
         chk("underrun", int'(underrun), int'(e_ur));
`endif
      end
      known = 1;
      if (rst) begin
         e_de = 0; e_hs = 1; e_vs = 1; e_ur = 0; pend = 0; t = 0;
      end else begin
         e_de = act;
         e_hs = !(h >= 5 && h <= 6);
         e_vs = !(v == 4);
         e_ur = e_ur || (act && e);
         pend = exp_re;
         t    = t + 1;
      end
      if (pend) begin
         cur_word = w;
         w = (w == 7) ? 1 : w + 1;
      end
      e_rgb = pend ? cur_word : 0;
   endtask

   initial begin
      int pops;
      int de_cnt;
      int hs_lo;
      int vs_lo;
      int pre;
      reset      = 1'b1;
      E          = 1'b0;
      dataIn_RGB = 3'b000;

      // Reset held two cycles; RE must stay low even though E=0.
      cyc(0, 1);
      chk("RE_in_reset", int'(RE), 0);
      cyc(0, 1);
      chk("RE_in_reset2", int'(RE), 0);
      chk("hsync_reset", int'(hsync), 1);
      chk("vsync_reset", int'(vsync), 1);

      // Frame 1, FIFO never empty.
      pops = 0; de_cnt = 0; hs_lo = 0; vs_lo = 0;
      for (int i = 0; i < 49; i++) begin
         cyc(0, 0);
         if (i == 0) chk("first_RE", int'(RE), 1);
         if (i == 1) chk("first_pixel", int'(dataOut_RGB), 1);
         if (i < 48) pops += int'(RE);
         if (i >= 1) begin
            de_cnt += int'(de);
            hs_lo  += int'(!hsync);
            vs_lo  += int'(!vsync);
         end
      end
      chk("pops_per_frame", pops, 12);
      chk("de_per_frame", de_cnt, 12);
      chk("hsync_low_cycles", hs_lo, 12);
      chk("vsync_low_cycles", vs_lo, 8);

      // Frame 2 with a single underrun at line 1, pixel 2.
      while (t < 96) begin
         pre = t % 48;
         cyc(pre == 10, 0);
         if (pre == 10) chk("underrun_no_pop", int'(RE), 0);
         if (pre == 11) begin
            chk("underrun_black", int'(dataOut_RGB), 0);
            chk("underrun_resume", int'(RE), 1);
`ifdef VGA_UNDERRUN_FLAG_EN
            chk("underrun_flag", int'(underrun), 1);
`endif
         end
      end

      // Frame 3 with random FIFO empty flag.
      while (t < 144) cyc(1'($urandom_range(0, 1)), 0);

      // Mid-frame reset at vcnt=2, hcnt=3.
      while (t % 48 != 19) cyc(0, 0);
      cyc(0, 1);
      chk("RE_midreset", int'(RE), 0);
      cyc(0, 0);
      chk("de_after_reset", int'(de), 0);
      chk("hsync_after_reset", int'(hsync), 1);
      chk("vsync_after_reset", int'(vsync), 1);
      chk("rgb_after_reset", int'(dataOut_RGB), 0);
      chk("RE_restart", int'(RE), 1);
`ifdef VGA_UNDERRUN_FLAG_EN
      chk("underrun_cleared", int'(underrun), 0);
`endif
      for (int i = 0; i < 50; i++) cyc(0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
